// File: rtl/ppu_mixer_pkg.sv
// Shared constants for the PPU layer mixer: register map, reset values, limits.
package ppu_mixer_pkg;

  localparam int unsigned MAX_LAYERS = 32;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REF_W      = 5;
  localparam int unsigned POS_W      = 10;

  localparam logic [ADDR_W-1:0] ADDR_BG     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_KEY    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EN     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_REF    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd4;

  localparam logic [23:0]      BG_RST  = 24'h202020;
  localparam logic [23:0]      KEY_RST = 24'h202020;
  localparam logic [REF_W-1:0] REF_RST = 5'd3;

endpackage

// File: rtl/mixer_priority_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set request plus an any-set flag.
module mixer_priority_enc #(
  parameter int unsigned N = 20,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx_c = '0;
    any_c = |req;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ppu_layer_mixer.sv
// Two-stage layer compositor with enable mask, transparent key, background colour
// and per-frame collision flags against a reference layer.
module ppu_layer_mixer
  import ppu_mixer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 20,
  parameter int unsigned COLOR_W    = 24,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic                          read,
  input  logic [ADDR_W-1:0]             address,
  input  logic [REG_W-1:0]              writedata,
  output logic [REG_W-1:0]              readdata,
  input  logic [POS_W-1:0]              hcount,
  input  logic [POS_W-1:0]              vcount,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  output logic [COLOR_W-1:0]            RGB_output,
  output logic [POS_W-1:0]              hcount_out,
  output logic [POS_W-1:0]              vcount_out
);

  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  // Software-visible registers
  logic [COLOR_W-1:0]    bg_color;
  logic [COLOR_W-1:0]    key_color;
  logic [NUM_LAYERS-1:0] layer_en;
  logic [REF_W-1:0]      ref_layer;
  logic [NUM_LAYERS-1:0] collision_acc;
  logic [NUM_LAYERS-1:0] collision_status;

  // Stage 1 pipeline registers
  logic [NUM_LAYERS-1:0] s1_opaque;
  logic [COLOR_W-1:0]    s1_rgb [NUM_LAYERS];
  logic [COLOR_W-1:0]    s1_bg;
  logic [POS_W-1:0]      s1_h;
  logic [POS_W-1:0]      s1_v;
  logic                  s1_frame;
  logic                  s1_visible;

  logic [COLOR_W-1:0]    layer_c [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] opaque_c;
  logic                  ref_opaque_c;
  logic [NUM_LAYERS-1:0] hits_c;
  logic [REG_W-1:0]      rd_c;
  logic [IDX_W-1:0]      sel_idx_c;
  logic                  sel_any_c;
  logic                  wr_unused_c;

  // Upper writedata bits beyond each field are deliberately dropped
  assign wr_unused_c = ^writedata;

  // Split the layer bus and classify each layer as opaque or transparent
  always_comb begin
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      layer_c[i]  = layer_rgb[i*COLOR_W +: COLOR_W];
      opaque_c[i] = layer_en[i] && (layer_c[i] != key_color);
    end
  end

  // Register file writes; status is read-only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg_color  <= COLOR_W'(BG_RST);
      key_color <= COLOR_W'(KEY_RST);
      layer_en  <= '1;
      ref_layer <= REF_RST;
    end else if (write) begin
      case (address)
        ADDR_BG:  bg_color  <= writedata[COLOR_W-1:0];
        ADDR_KEY: key_color <= writedata[COLOR_W-1:0];
        ADDR_EN:  layer_en  <= writedata[NUM_LAYERS-1:0];
        ADDR_REF: ref_layer <= writedata[REF_W-1:0];
        default:  ;
      endcase
    end
  end

  // Read mux over pre-edge register values
  always_comb begin
    rd_c = '0;
    case (address)
      ADDR_BG:     rd_c = REG_W'(bg_color);
      ADDR_KEY:    rd_c = REG_W'(key_color);
      ADDR_EN:     rd_c = REG_W'(layer_en);
      ADDR_REF:    rd_c = REG_W'(ref_layer);
      ADDR_STATUS: rd_c = REG_W'(collision_status);
      default:     rd_c = '0;
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else if (read) readdata <= rd_c;
  end

  // Stage 1: capture opaque mask, colours, position and frame-start marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_opaque  <= '0;
      for (int i = 0; i < int'(NUM_LAYERS); i++) s1_rgb[i] <= '0;
      s1_bg      <= COLOR_W'(BG_RST);
      s1_h       <= '0;
      s1_v       <= '0;
      s1_frame   <= 1'b0;
      s1_visible <= 1'b0;
    end else begin
      s1_opaque  <= opaque_c;
      s1_rgb     <= layer_c;
      s1_bg      <= bg_color;
      s1_h       <= hcount;
      s1_v       <= vcount;
      s1_frame   <= (hcount == '0) && (vcount == '0);
      s1_visible <= (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
    end
  end

  // Collision hits for the stage-1 pixel; an out-of-range reference never matches
  always_comb begin
    ref_opaque_c = 1'b0;
    for (int j = 0; j < int'(NUM_LAYERS); j++) begin
      if (REF_W'(j) == ref_layer) ref_opaque_c = s1_opaque[j];
    end
    for (int j = 0; j < int'(NUM_LAYERS); j++) begin
      hits_c[j] = s1_opaque[j] && ref_opaque_c && s1_visible && (REF_W'(j) != ref_layer);
    end
  end

  // Per-frame collision accumulation and status snapshot at frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_acc    <= '0;
      collision_status <= '0;
    end else if (s1_frame) begin
      collision_status <= collision_acc;
      collision_acc    <= hits_c;
    end else begin
      collision_acc    <= collision_acc | hits_c;
    end
  end

  mixer_priority_enc #(
    .N (NUM_LAYERS)
  ) u_prio (
    .req   (s1_opaque),
    .idx_c (sel_idx_c),
    .any_c (sel_any_c)
  );

  // Stage 2: select the winning layer or the background
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RGB_output <= COLOR_W'(BG_RST);
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      RGB_output <= sel_any_c ? s1_rgb[sel_idx_c] : s1_bg;
      hcount_out <= s1_h;
      vcount_out <= s1_v;
    end
  end

endmodule

// File: tb/tb_ppu_layer_mixer.sv
// Directed self-checking bench for ppu_layer_mixer (20 layers, 24-bit colour).
module tb_ppu_layer_mixer;

  localparam int unsigned NL = 20;
  localparam int unsigned CW = 24;

  logic            clk;
  logic            reset;
  logic            write;
  logic            read;
  logic [2:0]      address;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic [9:0]      hcount;
  logic [9:0]      vcount;
  logic [NL*CW-1:0] layer_rgb;
  logic [CW-1:0]   RGB_output;
  logic [9:0]      hcount_out;
  logic [9:0]      vcount_out;

  int checks = 0;
  int errors = 0;

  ppu_layer_mixer #(
    .NUM_LAYERS (NL),
    .COLOR_W    (CW),
    .H_ACTIVE   (640),
    .V_ACTIVE   (480)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .layer_rgb  (layer_rgb),
    .RGB_output (RGB_output),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [23:0] c);
    for (int i = 0; i < int'(NL); i++) layer_rgb[i*CW +: CW] = c;
  endtask

  task automatic set_layer(input int i, input logic [23:0] c);
    layer_rgb[i*CW +: CW] = c;
  endtask

  task automatic pixel(input logic [9:0] h, input logic [9:0] v);
    hcount = h;
    vcount = v;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    read    = 1'b1;
    step();
    read    = 1'b0;
  endtask

  // Presents (0,0) for one cycle so the next cycle snapshots the collision status
  task automatic frame_boundary();
    pixel(10'd0, 10'd0);
    step();
    pixel(10'd5, 10'd5);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    pixel(10'd1, 10'd1);
    set_all(24'h202020);
    step();
    check("rst_rgb", 32'(RGB_output), 32'h202020);
    check("rst_hcnt", 32'(hcount_out), 32'd0);
    check("rst_vcnt", 32'(vcount_out), 32'd0);
    check("rst_rdata", readdata, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("idle_rgb", 32'(RGB_output), 32'h202020);
    rd(3'd2); check("rd_en_rst", readdata, 32'h000FFFFF);
    rd(3'd3); check("rd_ref_rst", readdata, 32'd3);
    rd(3'd1); check("rd_key_rst", readdata, 32'h202020);
    rd(3'd4); check("rd_status_rst", readdata, 32'd0);
    rd(3'd6); check("rd_unused", readdata, 32'd0);
    wr(3'd4, 32'hFFFFFFFF);
    rd(3'd4); check("status_ro", readdata, 32'd0);

    // Priority: layer 3 beats layer 5
    pixel(10'd10, 10'd10);
    set_layer(3, 24'hFF0000);
    set_layer(5, 24'h00FF00);
    step(); step();
    check("prio_rgb", 32'(RGB_output), 32'hFF0000);
    check("prio_hcnt", 32'(hcount_out), 32'd10);
    check("prio_vcnt", 32'(vcount_out), 32'd10);
    wr(3'd2, 32'h000FFFF7);
    check("en_before", 32'(RGB_output), 32'hFF0000);
    step();
    check("en_write_cycle_old", 32'(RGB_output), 32'hFF0000);
    step();
    check("en_new", 32'(RGB_output), 32'h00FF00);
    wr(3'd2, 32'h000FFFFF);

    // Background when everything matches the key
    wr(3'd0, 32'hFF5C94FC);
    wr(3'd1, 32'h0);
    set_all(24'h000000);
    step(); step();
    check("bg_rgb", 32'(RGB_output), 32'h5C94FC);
    wr(3'd1, 32'h5C94FC);
    set_all(24'h5C94FC);
    step(); step();
    check("key_eq_bg", 32'(RGB_output), 32'h5C94FC);
    wr(3'd1, 32'h0);
    set_all(24'h000000);

    // Simultaneous read and write of one address returns the old value
    address = 3'd0; writedata = 32'h123456; read = 1'b1; write = 1'b1;
    step();
    read = 1'b0; write = 1'b0;
    check("rw_same_old", readdata, 32'h5C94FC);
    rd(3'd0); check("rw_same_new", readdata, 32'h123456);
    wr(3'd0, 32'h5C94FC);

    // Earlier overlap of layers 3 and 5 at (10,10) leaves bit 5 pending
    frame_boundary();
    rd(3'd4); check("status_prev_hits", readdata, 32'h20);
    frame_boundary();
    rd(3'd4); check("status_clear", readdata, 32'h0);

    // Overlap of layers 3 and 14 at (100,200)
    pixel(10'd100, 10'd200);
    set_layer(3, 24'h111111);
    set_layer(14, 24'h222222);
    step(); step();
    check("ovl_rgb", 32'(RGB_output), 32'h111111);
    set_all(24'h000000);
    pixel(10'd5, 10'd5);
    rd(3'd4); check("status_during_frame", readdata, 32'h0);
    frame_boundary();
    rd(3'd4); check("status_bit14", readdata, 32'h4000);

    // Overlap outside the visible area does not count
    pixel(10'd700, 10'd200);
    set_layer(3, 24'h111111);
    set_layer(14, 24'h222222);
    step();
    set_all(24'h000000);
    pixel(10'd5, 10'd5);
    step();
    check("offscreen_hcnt", 32'(hcount_out), 32'd700);
    step();
    frame_boundary();
    rd(3'd4); check("status_offscreen", readdata, 32'h0);

    // Out-of-range reference layer records nothing
    wr(3'd3, 32'd31);
    rd(3'd3); check("rd_ref31", readdata, 32'd31);
    pixel(10'd100, 10'd100);
    set_layer(3, 24'h333333);
    set_layer(5, 24'h555555);
    step(); step();
    check("ref31_rgb", 32'(RGB_output), 32'h333333);
    set_all(24'h000000);
    frame_boundary();
    rd(3'd4); check("status_ref31", readdata, 32'h0);

    // Mid-frame asynchronous reset with pending hits
    wr(3'd3, 32'd3);
    pixel(10'd50, 10'd50);
    set_layer(3, 24'h333333);
    set_layer(5, 24'h555555);
    step(); step();
    check("pre_rst_rgb", 32'(RGB_output), 32'h333333);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rgb", 32'(RGB_output), 32'h202020);
    check("async_rst_hcnt", 32'(hcount_out), 32'd0);
    check("async_rst_vcnt", 32'(vcount_out), 32'd0);
    set_all(24'h202020);
    pixel(10'd5, 10'd5);
    step(); step();
    reset = 1'b0;
    step(); step();
    check("post_rst_rgb", 32'(RGB_output), 32'h202020);
    rd(3'd3); check("post_rst_ref", readdata, 32'd3);
    rd(3'd0); check("post_rst_bg", readdata, 32'h202020);
    rd(3'd2); check("post_rst_en", readdata, 32'h000FFFFF);
    frame_boundary();
    rd(3'd4); check("post_rst_status", readdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
